// File: rtl/rr_arbiter32.sv
// Round-robin arbiter: grants one of N requesters, drives the mux select index,
// and holds the grant until release, request drop, or the hold limit expires.
module rr_arbiter32 #(
   parameter int N        = 32,
   parameter int SELW     = 5,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            release_i,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] sel,
   output logic            busy,
   output logic            timeout_o,
   output logic            fsm_state
);

   localparam int CNTW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);
   localparam logic [N-1:0]    ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state;
   logic [SELW-1:0] ptr;
   logic [CNTW-1:0] hold_cnt;
   logic            found;
   logic [SELW-1:0] pick;
   logic            owner_done;
   logic            hold_expired;
   logic [SELW-1:0] ptr_after;

   // Index ptr+off wrapped into 0..N-1; valid for any N, not only powers of two.
   function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                input int unsigned     off);
      int unsigned s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return SELW'(s);
   endfunction

   // Scan from the far end so the closest requester to ptr is the last writer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req[wrap_add(ptr, j)]) begin
            found = 1'b1;
            pick  = wrap_add(ptr, j);
         end
      end
   end

   always_comb begin
      owner_done   = release_i || !req[sel];
      hold_expired = (MAX_HOLD > 0) && (hold_cnt == CNTW'(HOLD_LAST));
      ptr_after    = (sel == LAST_IDX) ? '0 : sel + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         gnt       <= '0;
         sel       <= '0;
         busy      <= 1'b0;
         timeout_o <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt      <= ONE_HOT0 << pick;
                  sel      <= pick;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               hold_cnt <= hold_cnt + 1'b1;
               // Release or request drop wins over the hold limit: no timeout pulse then.
               if (owner_done || hold_expired) begin
                  gnt       <= '0;
                  busy      <= 1'b0;
                  ptr       <= ptr_after;
                  state     <= IDLE;
                  timeout_o <= !owner_done;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fsm_state = state;

endmodule
